// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: datapath widths, opcode map,
// NOP encoding and fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int OPERAND_WIDTH     = 32;
  localparam int INSTRUCTION_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ALU     = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_ENCODING = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_buf.sv
// One-entry output buffer of the fetch stage: holds the fetched word, its pc
// and the illegal flag; flush and consume both fall back to NOP_INST.
// Optional IFETCH_MISALIGN_TRAP_EN adds a registered misalign flag.
module ifetch_buf
  import inst_fetch_pkg::*;
#(
  parameter logic [OPERAND_WIDTH-1:0]     RESET_PC = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INST = NOP_ENCODING
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         load_i,
  input  logic [INSTRUCTION_WIDTH-1:0] load_inst_i,
  input  logic [OPERAND_WIDTH-1:0]     load_pc_i,
`ifdef IFETCH_MISALIGN_TRAP_EN
  input  logic                         load_misalign_i,
  output logic                         misalign_o,
`endif
  input  logic                         ready_i,
  output logic [INSTRUCTION_WIDTH-1:0] inst_o,
  output logic [OPERAND_WIDTH-1:0]     pc_o,
  output logic                         valid_o,
  output logic                         illegal_o
);

  logic [INSTRUCTION_WIDTH-1:0] inst_q, inst_d;
  logic [OPERAND_WIDTH-1:0]     pc_q, pc_d;
  logic                         valid_q, valid_d;
  logic                         illegal_q, illegal_d;

  // Flush beats load beats consume; an empty buffer always shows NOP_INST.
  always_comb begin
    inst_d    = inst_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      inst_d    = NOP_INST;
      illegal_d = (NOP_INST[1:0] != 2'b11);
    end else if (load_i) begin
      valid_d   = 1'b1;
      inst_d    = load_inst_i;
      pc_d      = load_pc_i;
      illegal_d = (load_inst_i[1:0] != 2'b11);
    end else if (valid_q && ready_i) begin
      valid_d   = 1'b0;
      inst_d    = NOP_INST;
      illegal_d = (NOP_INST[1:0] != 2'b11);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_q    <= NOP_INST;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (flush_i)                   misalign_d = 1'b0;
    else if (load_i)               misalign_d = load_misalign_i;
    else if (valid_q && ready_i)   misalign_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`endif

  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: pc, single-outstanding imem requests, redirect/drain FSM.
// Optional IFETCH_MISALIGN_TRAP_EN reports misaligned redirect targets.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [OPERAND_WIDTH-1:0]     RESET_PC = 32'h0000_0000,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INST = NOP_ENCODING
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [OPERAND_WIDTH-1:0]     imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] inst,
  output logic [OPERAND_WIDTH-1:0]     inst_pc,
  output logic                         inst_valid,
  output logic                         inst_illegal,
  input  logic                         inst_ready,
  input  logic                         redirect_valid,
  input  logic [OPERAND_WIDTH-1:0]     redirect_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic                         inst_misalign,
`endif
  output fetch_state_e                 dbg_state
);

  fetch_state_e                 state_q;
  logic [OPERAND_WIDTH-1:0]     pc_q;
  logic [OPERAND_WIDTH-1:0]     drain_pc_q;
  logic                         pending_q;

  logic [OPERAND_WIDTH-1:0]     redir_pc;
  logic                         req_open;
  logic                         fetch_ack;
  logic                         trap;
  logic                         halt;
  logic                         buf_load;
  logic                         buf_flush;
  logic [INSTRUCTION_WIDTH-1:0] buf_inst;
  logic [OPERAND_WIDTH-1:0]     buf_pc;

  assign redir_pc = redirect_pc & ~OPERAND_WIDTH'(3);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic halted_q;
  assign trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign halt = halted_q;
`else
  assign trap = 1'b0;
  assign halt = 1'b0;
`endif

  // Handshake: a request raised without ack stays up with the same address
  // until ack; no new request while the buffer holds an unconsumed word.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      FETCH:   imem_req = pending_q || (!halt && (!inst_valid || inst_ready));
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;
  assign req_open  = imem_req && !imem_ack;
  assign fetch_ack = (state_q == FETCH) && imem_req && imem_ack && !redirect_valid;

  assign buf_load  = fetch_ack || trap;
  assign buf_flush = redirect_valid && !trap;
  assign buf_inst  = trap ? NOP_INST : imem_rdata;
  assign buf_pc    = trap ? redirect_pc : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      drain_pc_q <= RESET_PC;
      pending_q  <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (redirect_valid) pc_q <= redir_pc;
        end
        FETCH: begin
          if (redirect_valid) begin
            pending_q <= 1'b0;
            // A request the memory has seen but not answered must drain first.
            if (req_open) begin
              state_q    <= DRAIN;
              drain_pc_q <= redir_pc;
            end else begin
              pc_q <= redir_pc;
            end
          end else if (imem_req && imem_ack) begin
            pending_q <= 1'b0;
            pc_q      <= pc_q + OPERAND_WIDTH'(4);
          end else begin
            pending_q <= imem_req;
          end
        end
        DRAIN: begin
          if (redirect_valid) drain_pc_q <= redir_pc;
          if (imem_ack) begin
            state_q <= FETCH;
            pc_q    <= redirect_valid ? redir_pc : drain_pc_q;
          end
        end
        default: begin
          state_q   <= BOOT;
          pending_q <= 1'b0;
        end
      endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (redirect_valid) halted_q <= trap;
`endif
    end
  end

  ifetch_buf #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_buf (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (buf_flush),
    .load_i          (buf_load),
    .load_inst_i     (buf_inst),
    .load_pc_i       (buf_pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .load_misalign_i (trap),
    .misalign_o      (inst_misalign),
`endif
    .ready_i         (inst_ready),
    .inst_o          (inst),
    .pc_o            (inst_pc),
    .valid_o         (inst_valid),
    .illegal_o       (inst_illegal)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural memory with configurable ack latency and a
// program-order model of the delivered instruction stream.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_valid;
  logic         inst_illegal;
  logic         inst_ready = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic         inst_misalign;
`endif
  fetch_state_e dbg_state;

  inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_illegal   (inst_illegal),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .inst_misalign  (inst_misalign),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_bad    = 0;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_a;
  int          lat_cfg;
  logic [31:0] exp_next;
  logic [31:0] exp_q[$];
  bit          prev_open;
  bit          prev_redir;
  logic [31:0] prev_addr;
  int          n_consumed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents; a few fixed words for the directed cases.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0010: return 32'h0000_0000;
      32'h0000_0014: return 32'h0000_0013;
      default:       return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  // One clock cycle: drive inputs, answer memory, then check and update model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    logic [31:0] w;
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
    #1;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_a    = imem_addr;
        mem_wait = (lat_cfg < 0) ? int'($urandom_range(0, 2)) : lat_cfg;
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(mem_a);
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    if (prev_open) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, prev_addr);
    end
    if (imem_req) check("addr_align", imem_addr[1:0], 0);
    if (prev_redir) check("flush_valid", inst_valid, 0);
    if (inst_valid && !inst_ready && !prev_open) check("stall_noreq", imem_req, 0);
    if (!inst_valid) begin
      check("idle_nop", inst, NOP);
      check("idle_illegal", inst_illegal, 0);
    end
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) exp_q.push_back(exp_next);
      w = mem_word(exp_q[0]);
      check("seq_pc", inst_pc, exp_q[0]);
      check("seq_inst", inst, w);
      check("seq_illegal", inst_illegal, (w[1:0] != 2'b11));
      exp_next = exp_q.pop_front() + 32'd4;
      n_consumed++;
    end
    if (rv) begin
      exp_q.delete();
      exp_next = rpc & ~32'h3;
    end
    prev_open  = imem_req && !imem_ack;
    prev_addr  = imem_addr;
    prev_redir = rv;
  endtask

  task automatic do_reset(input int lat);
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    mem_busy       = 1'b0;
    prev_open      = 1'b0;
    prev_redir     = 1'b0;
    exp_next       = RST_PC;
    exp_q.delete();
    lat_cfg        = lat;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_req", imem_req, 0);
    check("rst_inst", inst, NOP);
    check("rst_pc", inst_pc, RST_PC);
    check("rst_valid", inst_valid, 0);
    check("rst_illegal", inst_illegal, 0);
    check("rst_state", dbg_state, BOOT);
  endtask

  initial begin
    bit          r_rdy;
    bit          r_rv;
    logic [31:0] r_pc;
    int          base;

    // Zero-wait stream, then a 3-cycle stall at pc 8.
    do_reset(0);
    step(1, 0, 0);
    check("t1_req", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);
    step(1, 0, 0);
    check("t1_inst", inst, 32'h0050_0093);
    check("t1_pc", inst_pc, 32'h0);
    check("t1_valid", inst_valid, 1);
    check("t1_addr4", imem_addr, 32'h4);
    step(1, 0, 0);
    check("t1_addr8", imem_addr, 32'h8);
    check("t1_pc4", inst_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("t2_stall_pc", inst_pc, 32'h8);
      check("t2_stall_inst", inst, mem_word(32'h8));
      check("t2_stall_valid", inst_valid, 1);
      check("t2_stall_req", imem_req, 0);
    end
    step(1, 0, 0);
    check("t2_release_req", imem_req, 1);
    check("t2_release_addr", imem_addr, 32'hC);

    // Two-cycle memory, redirect while addr 4 is outstanding.
    do_reset(2);
    repeat (3) step(1, 0, 0);
    step(1, 0, 0);
    check("t3_valid0", inst_valid, 1);
    check("t3_req4", imem_req, 1);
    check("t3_addr4", imem_addr, 32'h4);
    step(1, 1, 32'h100);
    step(1, 0, 0);
    check("t3_drain_state", dbg_state, DRAIN);
    check("t3_drain_addr", imem_addr, 32'h4);
    check("t3_drain_ack", imem_ack, 1);
    check("t3_drain_valid", inst_valid, 0);
    step(1, 0, 0);
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_new_req", imem_req, 1);
    check("t3_no_stale", inst_valid, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("t3_target_valid", inst_valid, 1);
    check("t3_target_pc", inst_pc, 32'h100);

    // Redirect with same-cycle ack, illegal word, pc wrap.
    do_reset(0);
    step(1, 0, 0);
    step(1, 1, 32'h204);
    check("t4_same_ack", imem_ack, 1);
    step(1, 0, 0);
    check("t4_flushed", inst_valid, 0);
    check("t4_addr", imem_addr, 32'h204);
    step(1, 1, 32'h13);
    check("t4_pc", inst_pc, 32'h204);
    check("t4_inst", inst, mem_word(32'h204));
    step(1, 0, 0);
    check("t5_addr_masked", imem_addr, 32'h10);
    step(1, 0, 0);
    check("t5_ill_valid", inst_valid, 1);
    check("t5_ill_inst", inst, 32'h0);
    check("t5_ill_flag", inst_illegal, 1);
    step(1, 1, 32'hFFFF_FFFC);
    check("t5_ok_inst", inst, 32'h0000_0013);
    check("t5_ok_flag", inst_illegal, 0);
    step(1, 0, 0);
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0);
    check("t6_addr_wrap", imem_addr, 32'h0);
    check("t6_pc_top", inst_pc, 32'hFFFF_FFFC);
    step(1, 0, 0);
    check("t6_pc_wrap", inst_pc, 32'h0);

    // Asynchronous reset while a request is outstanding.
    do_reset(2);
    repeat (4) step(1, 0, 0);
    check("t7_pre_req", imem_req, 1);
    check("t7_pre_valid", inst_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_req_drop", imem_req, 0);
    check("t7_valid_drop", inst_valid, 0);
    check("t7_inst_nop", inst, NOP);

    // Random ready, redirects and memory latency.
    do_reset(-1);
    base = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) r_pc = $urandom;
      else                           r_pc = {20'h0, 12'($urandom_range(0, 4095))};
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_pc = r_pc & ~32'h3;
`endif
      step(r_rdy, r_rv, r_pc);
    end
    check("rand_progress", (n_consumed - base) >= 300, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
